neuron_acc_ctrl: RTL and testbench
==================================

NEURON_ACC_CTRL -- requirements
Module: neuron_acc_ctrl

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 12, accumulator and result width (signed).
REQ-002 SHALL have parameter LEN_WIDTH, default 10, term-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse requesting a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_WIDTH  number of terms to accumulate; sampled with start.
REQ-007 SHALL have port bias  input  ACC_WIDTH  signed initial accumulator value; sampled with start.
REQ-008 SHALL have port in_valid  input  1  term valid.
REQ-009 SHALL have port in_bit  input  1  term value: 1 means +1, 0 means -1.
REQ-010 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_data  output  ACC_WIDTH  signed result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-016 IDLE: on start=1, SHALL load acc<=bias and cnt<=len; next state ACCUM if len!=0, else DONE.
REQ-017 ACCUM: in_ready SHALL be 1; a term is accepted when in_valid&&in_ready.
REQ-018 On accept, SHALL drive the ALU with alu_in_a_lsb=1, alu_op=0 when in_bit=1 (add) or alu_op=1 when in_bit=0 (sub), alu_in_b=acc, and register the ALU output into acc in the same cycle; cnt decrements by 1.
REQ-019 Saturation: if acc==2^(ACC_WIDTH-1)-1 and in_bit=1, acc SHALL hold; if acc==-2^(ACC_WIDTH-1) and in_bit=0, acc SHALL hold; cnt still decrements; no wrap-around permitted.
REQ-020 When a term is accepted with cnt==1, SHALL transition to DONE on the next edge.
REQ-021 Cycles with in_valid=0 in ACCUM SHALL leave acc and cnt unchanged (stall, no timeout).
REQ-022 in_ready SHALL be 0 in IDLE and DONE; in_valid there is ignored.
REQ-023 DONE: out_valid SHALL be 1 and out_data SHALL equal acc, stable until out_valid&&out_ready; then next state IDLE.
REQ-024 out_data SHALL equal acc in all states; consumers qualify it with out_valid only.
REQ-025 start in ACCUM or DONE SHALL be ignored (no restart, no queueing).
REQ-026 start in the same cycle as the DONE handshake SHALL be ignored; start is honoured only while in IDLE.
REQ-027 Latency: with in_valid held high, out_valid SHALL assert len+1 cycles after the start cycle (1 cycle for len=0).

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, acc=0, cnt=0.
REQ-029 Reset values: in_ready=0, out_valid=0, out_data=0, busy=0.
REQ-030 Reset asserted mid-ACCUM or mid-DONE SHALL abort the operation; no result emitted after reset release until a new start.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and ALU op constants (ADD1=1'b0, SUB1=1'b1).
REQ-032 SHALL instantiate exactly one sub-module, the existing alu, with alu_width=ACC_WIDTH; saturation check and registers live in neuron_acc_ctrl.
REQ-033 Implementation SHALL be synchronous except for the reset; no combinational path from in_valid to out_valid.

Verification
REQ-034 start, len=4, bias=0, in_bit=1,1,0,1 contiguous, out_ready=1 -> out_data=+2, out_valid 5 cycles after start, then IDLE.
REQ-035 start, len=0, bias=-7 -> out_valid next cycle with out_data=-7; in_ready never asserted.
REQ-036 bias=2045, len=5, all in_bit=1 -> out_data=2047 (saturated); bias=-2046, len=4, all 0 -> -2048.
REQ-037 len=3, in_valid gapped (1,0,0,1,0,1), out_ready low 3 cycles in DONE -> result held stable, out_valid stays high until handshake; extra start pulses ignored.
REQ-038 rst_n pulsed low after 2 of 6 terms -> immediate IDLE, acc=0, out_valid=0; subsequent start len=2 bias=5 bits 0,0 -> out_data=3.

Source files
------------

// File: rtl/neuron_acc_ctrl_pkg.sv
// Shared definitions for the ternary-free (+1/-1) neuron accumulator:
// FSM state encoding and the ALU operation codes.
package neuron_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic ADD1 = 1'b0;
    localparam logic SUB1 = 1'b1;

endpackage

// File: rtl/neuron_acc_ctrl_alu.sv
// Small add/sub ALU: alu_out = alu_in_b +/- {0..0, alu_in_a_lsb}.
// Purely combinational; wrap-around is the caller's concern.
module neuron_acc_ctrl_alu
    import neuron_acc_ctrl_pkg::*;
#(
    parameter int alu_width = 12
) (
    input  logic                 alu_in_a_lsb,
    input  logic                 alu_op,
    input  logic [alu_width-1:0] alu_in_b,
    output logic [alu_width-1:0] alu_out
);

    logic [alu_width-1:0] a_ext;

    assign a_ext = {{(alu_width-1){1'b0}}, alu_in_a_lsb};

    // Select increment or decrement of operand b.
    always_comb begin
        alu_out = alu_in_b + a_ext;
        if (alu_op == SUB1) begin
            alu_out = alu_in_b - a_ext;
        end
    end

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Neuron accumulator controller: loads a bias, then adds +1/-1 per accepted
// term (saturating at the signed limits) for len terms, and presents the
// result with a valid/ready handshake.
module neuron_acc_ctrl
    import neuron_acc_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH = 12,
    parameter int LEN_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic        [LEN_WIDTH-1:0] len,
    input  logic signed [ACC_WIDTH-1:0] bias,
    input  logic                        in_valid,
    input  logic                        in_bit,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_data,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_e                       state_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic        [LEN_WIDTH-1:0]  cnt_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         busy_q;
    logic                         alu_op;
    logic        [ACC_WIDTH-1:0]  alu_out;
    logic                         accept;

    assign alu_op = in_bit ? ADD1 : SUB1;
    assign accept = in_valid && in_ready_q;

    neuron_acc_ctrl_alu #(
        .alu_width (ACC_WIDTH)
    ) u_alu (
        .alu_in_a_lsb (1'b1),
        .alu_op       (alu_op),
        .alu_in_b     (acc_q),
        .alu_out      (alu_out)
    );

    // Next accumulator value: ALU result unless the step would cross a signed limit.
    always_comb begin
        acc_d = alu_out;
        if ((in_bit && (acc_q == ACC_MAX)) || (!in_bit && (acc_q == ACC_MIN))) begin
            acc_d = acc_q;
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= bias;
                        cnt_q  <= len;
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start here is deliberately ignored, even on the handshake cycle
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Self-checking bench for neuron_acc_ctrl: directed scenarios plus randomized
// transactions, compared against an integer reference model.
module tb_neuron_acc_ctrl;

    localparam int AW = 12;
    localparam int LW = 10;
    localparam int SMAX = 2047;
    localparam int SMIN = -2048;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic        [LW-1:0] len = '0;
    logic signed [AW-1:0] bias = '0;
    logic                 in_valid = 1'b0;
    logic                 in_bit = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [AW-1:0] out_data;
    logic                 out_ready = 1'b0;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    neuron_acc_ctrl #(
        .ACC_WIDTH (AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        if (observed != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start, feed n terms (random gaps), hold out_ready low
    // for hold cycles, then handshake. Returns the DUT result seen in DONE.
    task automatic do_txn(input int n, input int b, input logic [63:0] bits,
                          input int gap_pct, input int hold, output int result);
        int expv;
        int idx;
        int cycles;
        bit v;
        expv   = b;
        idx    = 0;
        cycles = 0;
        start  = 1'b1;
        len    = LW'(n);
        bias   = AW'(b);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        cycles = 1;
        start = 1'b0;
        while (idx < n) begin
            check("in_ready_accum", int'(in_ready), 1);
            check("out_valid_accum", int'(out_valid), 0);
            v = (int'($urandom_range(99)) >= gap_pct);
            in_valid = v;
            in_bit   = bits[idx];
            start    = 1'($urandom_range(1));
            len      = LW'($urandom_range(7));
            if (v) begin
                expv = clamp(expv + (bits[idx] ? 1 : -1));
                idx++;
            end
            tick();
            cycles++;
            if (cycles > 3000) begin
                check("accum_timeout", cycles, n + 1);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("out_valid_done", int'(out_valid), 1);
        check("in_ready_done", int'(in_ready), 0);
        check("busy_done", int'(busy), 1);
        check("out_data", int'(out_data), expv);
        if (gap_pct == 0) check("latency", cycles, n + 1);
        result = int'(out_data);
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            in_valid = 1'($urandom_range(1));
            in_bit   = 1'($urandom_range(1));
            tick();
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), expv);
        end
        out_ready = 1'b1;
        start     = 1'($urandom_range(1));
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_valid", int'(out_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 0);
        $display("[TB] txn len=%0d bias=%0d gap=%0d hold=%0d -> result=%0d expected=%0d",
                 n, b, gap_pct, hold, result, expv);
    endtask

    initial begin
        int res;
        logic [63:0] bits;

        // reset state
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // basic +1,+1,-1,+1
        bits = 64'b1011;
        do_txn(4, 0, bits, 0, 0, res);
        check("basic_result", res, 2);

        // zero length: result is the bias
        bits = '0;
        do_txn(0, -7, bits, 0, 0, res);
        check("len0_result", res, -7);

        // saturation at both limits
        bits = '1;
        do_txn(5, 2045, bits, 0, 0, res);
        check("sat_pos", res, 2047);
        bits = '0;
        do_txn(4, -2046, bits, 0, 0, res);
        check("sat_neg", res, -2048);

        // gapped input, backpressured output, stray starts
        bits = 64'($urandom);
        do_txn(3, 100, bits, 50, 3, res);

        // reset mid-ACCUM
        start = 1'b1; len = LW'(6); bias = AW'(9);
        tick();
        start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_acc", int'(out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        bits = 64'b00;
        do_txn(2, 5, bits, 0, 0, res);
        check("post_rst_result", res, 3);

        // reset mid-DONE
        start = 1'b1; len = '0; bias = AW'(33);
        tick();
        start = 1'b0;
        check("done_before_rst", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("done_abort_valid", int'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("done_abort_stays", int'(out_valid), 0);
        out_ready = 1'b0;

        // randomized transactions, some biased towards the limits
        for (int t = 0; t < 40; t++) begin
            int n, b, gap, hold;
            n    = int'($urandom_range(24));
            gap  = (t % 3 == 0) ? 0 : int'($urandom_range(60));
            hold = int'($urandom_range(3));
            bits = {$urandom, $urandom};
            case (t % 4)
                0: b = SMAX - int'($urandom_range(6));
                1: b = SMIN + int'($urandom_range(6));
                default: b = int'($urandom_range(4095)) - 2048;
            endcase
            if (t % 4 == 0) bits = '1;
            if (t % 4 == 1) bits = '0;
            do_txn(n, b, bits, gap, hold, res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // absolute guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
